key_sift_stream: RTL and testbench
==================================

// Module: key_sift_stream
// PURPOSE
//  Streaming, parametrised key sifter. Accepts sender/receiver basis-sifted bits LANE_W per beat over a
//  valid/ready stream, packs agreeing bits LSB-first into a KEY_W-bit key, and counts disagreements (QBER
//  numerator). Frame ends on s_last; result is held on a valid/ready output until consumed. Sits between
//  the basis-sifting stage and privacy amplification / key storage.
// PARAMETERS
//  KEY_W   128  key width in bits (>=2)
//  LANE_W  8    bits per input beat (1..KEY_W)
//  ERR_W   16   width of mismatch counter (saturating)
// PORTS
//  clk           in   1                      rising-edge clock
//  rst_n         in   1                      synchronous active-low reset
//  s_valid       in   1                      input beat valid
//  s_ready       out  1                      input beat accepted when s_valid&s_ready
//  s_last        in   1                      beat is last of frame
//  sender_bits   in   LANE_W                 sender sifted bits; bit 0 is earliest
//  receiver_bits in   LANE_W                 receiver sifted bits, same ordering
//  key_valid     out  1                      key/key_len/key_short/mismatch_cnt valid
//  key_ready     in   1                      consumer accepts result when key_valid&key_ready
//  key           out  KEY_W                  packed agreeing bits; unfilled bits 0
//  key_len       out  $clog2(KEY_W+1)        number of key bits filled (saturates at KEY_W)
//  key_short     out  1                      1 when key_len < KEY_W at frame end
//  mismatch_cnt  out  ERR_W                  disagreeing positions in frame, saturating at 2^ERR_W-1
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge): state=ACCUM; key=0, key_len=0, key_short=0, mismatch_cnt=0,
//   key_valid=0. Beats presented while rst_n==0 are ignored. s_ready = (state==ACCUM) && rst_n.
//  States: ACCUM (collect beats), HOLD (result presented).
//  ACCUM, accepted beat: for i=0..LANE_W-1 in order, if sender_bits[i]==receiver_bits[i], write
//   sender_bits[i] to key[fill] and increment fill, where fill starts at key_len plus matches of lower i.
//   Writes with fill>=KEY_W are discarded (overflow); key_len saturates at KEY_W.
//   Each disagreeing bit increments mismatch_cnt, saturating; it counts the whole frame, including
//   beats after the key is full.
//  All updates from a beat are visible the cycle after acceptance.
//  Accepted beat with s_last=1 -> HOLD next cycle; key_valid=1 in that same cycle, and key_short is
//   registered as (final key_len < KEY_W). Latency: last beat accepted at edge N -> key_valid high after N.
//  HOLD: s_ready=0; key, key_len, key_short and mismatch_cnt are stable; key_valid stays high until
//   key_ready. On key_valid&key_ready: clear all accumulators and outputs to reset values, key_valid=0,
//   return to ACCUM. The next beat can be accepted in the following cycle (no same-cycle bypass).
//  A frame may have fewer than KEY_W/LANE_W beats (short key) or more (overflow); both are legal.
//  A single-beat frame (s_last on first beat) is legal.
//  s_valid low in ACCUM: state holds; no update.
//  Reset mid-frame or in HOLD discards all partial state; the next frame is independent.
//  The datapath is a combinational per-lane prefix count of matches plus an indexed write. No
//   multi-cycle paths.
// TESTING
//  (KEY_W=16, LANE_W=8, ERR_W=16 unless noted)
//  T1 full key: beats (s=r=0xA5), (s=r=0x3C, last) -> key=0x3CA5, key_len=16, key_short=0, mismatch=0
//  T2 short key: s=0xFF, r=0x0F, last -> key=0x000F, key_len=4, key_short=1, mismatch_cnt=4
//  T3 overflow: s=r=0x11, 0x22, then (0x33, last) -> key=0x2211, key_len=16, key_short=0; 3rd beat dropped
//  T4 backpressure: hold key_ready=0 for 5 cycles after key_valid -> key_valid, key and counters stable;
//   s_ready=0; a pending s_valid beat is not consumed; it is accepted in the cycle after the handshake
//  T5 reset mid-frame: 1 beat 0xFF/0xFF, pulse rst_n=0 -> all outputs 0; then T2 stimulus gives T2 result
//  T6 saturation (ERR_W=4): 3 beats s=0x00, r=0xFF, last on 3rd -> mismatch_cnt=15, key_len=0, key=0,
//   key_short=1

Source files
------------

// File: rtl/key_sift_stream_if.sv
// Stream bundle for the key sifter.
// Carries the sifted-bit input beats and the held key result.
// slave  : the sifter's view of the bundle.
// master : the producer/consumer side of the bundle.
interface key_sift_stream_if #(
  parameter int KEY_W  = 128,
  parameter int LANE_W = 8,
  parameter int ERR_W  = 16
);
  localparam int LEN_W = $clog2(KEY_W + 1);

  // Input beat stream.
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [LANE_W-1:0] sender_bits;
  logic [LANE_W-1:0] receiver_bits;

  // Result stream.
  logic              key_valid;
  logic              key_ready;
  logic [KEY_W-1:0]  key;
  logic [LEN_W-1:0]  key_len;
  logic              key_short;
  logic [ERR_W-1:0]  mismatch_cnt;

  modport slave (
    input  s_valid, s_last, sender_bits, receiver_bits, key_ready,
    output s_ready, key_valid, key, key_len, key_short, mismatch_cnt
  );

  modport master (
    output s_valid, s_last, sender_bits, receiver_bits, key_ready,
    input  s_ready, key_valid, key, key_len, key_short, mismatch_cnt
  );
endinterface

// File: rtl/key_sift_stream.sv
// Streaming key sifter.
// Each accepted beat carries LANE_W sender/receiver bit pairs, bit 0 earliest.
// Agreeing pairs are appended LSB-first to the key; disagreeing pairs are counted.
// Once the key is full, further agreeing bits are dropped, but disagreements
// keep being counted until the end of the frame.
// At the end of a frame the result is held until the consumer takes it.
// Taking the result clears every accumulator for the next frame.
module key_sift_stream #(
  parameter int KEY_W  = 128,
  parameter int LANE_W = 8,
  parameter int ERR_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  key_sift_stream_if.slave bus
);

  localparam int LEN_W = $clog2(KEY_W + 1);
  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [LEN_W-1:0] KEY_FULL = LEN_W'(KEY_W);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Saturating increment of the disagreement counter.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == ERR_MAX) begin
      r = v;
    end else begin
      r = v + ERR_W'(1);
    end
    return r;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [KEY_W-1:0]  key_r;
  logic [KEY_W-1:0]  key_nxt_s;
  logic [LEN_W-1:0]  key_len_r;
  logic [LEN_W-1:0]  key_len_nxt_s;
  logic              key_short_r;
  logic              key_short_nxt_s;
  logic [ERR_W-1:0]  mismatch_r;
  logic [ERR_W-1:0]  mismatch_nxt_s;
  logic              key_valid_r;
  logic              key_valid_nxt_s;

  logic [KEY_W-1:0]  lane_key_s;
  logic [LEN_W-1:0]  lane_len_s;
  logic [ERR_W-1:0]  lane_err_s;
  logic              beat_fire_s;

  // Beats are refused while the result is held and while reset is asserted.
  assign bus.s_ready = (state_r == ST_ACCUM) && rst_n;
  assign beat_fire_s = bus.s_valid && bus.s_ready;

  assign bus.key_valid    = key_valid_r;
  assign bus.key          = key_r;
  assign bus.key_len      = key_len_r;
  assign bus.key_short    = key_short_r;
  assign bus.mismatch_cnt = mismatch_r;

  // Walk the lanes in order.
  // The running fill is the prefix count of matches: each agreeing bit lands
  // at the slot after the previous one. Writes past the last key slot are dropped.
  always_comb begin
    lane_key_s = key_r;
    lane_len_s = key_len_r;
    lane_err_s = mismatch_r;
    for (int i = 0; i < LANE_W; i++) begin
      if (bus.sender_bits[i] == bus.receiver_bits[i]) begin
        if (lane_len_s < KEY_FULL) begin
          lane_key_s[lane_len_s[IDX_W-1:0]] = bus.sender_bits[i];
          lane_len_s = lane_len_s + LEN_W'(1);
        end else begin
          lane_len_s = lane_len_s;
        end
      end else begin
        lane_err_s = err_sat_inc(lane_err_s);
      end
    end
  end

  // Frame control.
  // Accumulate beats until the last one, then hold the result until it is taken.
  always_comb begin
    state_nxt_s     = state_r;
    key_nxt_s       = key_r;
    key_len_nxt_s   = key_len_r;
    key_short_nxt_s = key_short_r;
    mismatch_nxt_s  = mismatch_r;
    key_valid_nxt_s = key_valid_r;
    case (state_r)
      ST_ACCUM: begin
        if (beat_fire_s) begin
          key_nxt_s      = lane_key_s;
          key_len_nxt_s  = lane_len_s;
          mismatch_nxt_s = lane_err_s;
          if (bus.s_last) begin
            state_nxt_s     = ST_HOLD;
            key_valid_nxt_s = 1'b1;
            key_short_nxt_s = (lane_len_s < KEY_FULL);
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (bus.key_ready) begin
          state_nxt_s     = ST_ACCUM;
          key_nxt_s       = {KEY_W{1'b0}};
          key_len_nxt_s   = {LEN_W{1'b0}};
          key_short_nxt_s = 1'b0;
          mismatch_nxt_s  = {ERR_W{1'b0}};
          key_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s     = ST_ACCUM;
        key_nxt_s       = {KEY_W{1'b0}};
        key_len_nxt_s   = {LEN_W{1'b0}};
        key_short_nxt_s = 1'b0;
        mismatch_nxt_s  = {ERR_W{1'b0}};
        key_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_ACCUM;
      key_r       <= {KEY_W{1'b0}};
      key_len_r   <= {LEN_W{1'b0}};
      key_short_r <= 1'b0;
      mismatch_r  <= {ERR_W{1'b0}};
      key_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_r       <= key_nxt_s;
      key_len_r   <= key_len_nxt_s;
      key_short_r <= key_short_nxt_s;
      mismatch_r  <= mismatch_nxt_s;
      key_valid_r <= key_valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_key_sift_stream.sv
// Bench for key_sift_stream.
// It drives two sifters from the same stimulus. The first has a 16-bit
// disagreement counter. The second has a 4-bit counter, so it reaches
// saturation quickly.
// A frame-level reference model predicts every result.
module tb_key_sift_stream;
  localparam int KW = 16;
  localparam int LW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: key bits collected so far, their count, disagreements
  logic [KW-1:0] m_key;
  int            m_len;
  int            m_mm;

  always #5 clk = ~clk;

  key_sift_stream_if #(.KEY_W(KW), .LANE_W(LW), .ERR_W(16)) bus ();
  key_sift_stream_if #(.KEY_W(KW), .LANE_W(LW), .ERR_W(4))  bus4 ();

  assign bus4.s_valid       = bus.s_valid;
  assign bus4.s_last        = bus.s_last;
  assign bus4.sender_bits   = bus.sender_bits;
  assign bus4.receiver_bits = bus.receiver_bits;
  assign bus4.key_ready     = bus.key_ready;

  key_sift_stream #(.KEY_W(KW), .LANE_W(LW), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  key_sift_stream #(.KEY_W(KW), .LANE_W(LW), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_key = '0;
    m_len = 0;
    m_mm  = 0;
  endtask

  // Agreeing bits go into the next free key slot while one remains.
  // Every disagreement is counted.
  task automatic model_beat(input logic [7:0] s, input logic [7:0] r);
    for (int i = 0; i < LW; i++) begin
      if (s[i] == r[i]) begin
        if (m_len < KW) begin
          m_key[m_len] = s[i];
          m_len = m_len + 1;
        end
      end else begin
        m_mm = m_mm + 1;
      end
    end
  endtask

  task automatic check_accum(input string tag);
    check({tag, "_valid"}, 64'(bus.key_valid), 64'(0));
    check({tag, "_key"},   64'(bus.key), 64'(m_key));
    check({tag, "_len"},   64'(bus.key_len), 64'(m_len));
    check({tag, "_short"}, 64'(bus.key_short), 64'(0));
    check({tag, "_mm16"},  64'(bus.mismatch_cnt), 64'(sat(m_mm, 65535)));
    check({tag, "_mm4"},   64'(bus4.mismatch_cnt), 64'(sat(m_mm, 15)));
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"},  64'(bus.key_valid), 64'(1));
    check({tag, "_valid4"}, 64'(bus4.key_valid), 64'(1));
    check({tag, "_key"},    64'(bus.key), 64'(m_key));
    check({tag, "_key4"},   64'(bus4.key), 64'(m_key));
    check({tag, "_len"},    64'(bus.key_len), 64'(m_len));
    check({tag, "_short"},  64'(bus.key_short), 64'(m_len < KW));
    check({tag, "_mm16"},   64'(bus.mismatch_cnt), 64'(sat(m_mm, 65535)));
    check({tag, "_mm4"},    64'(bus4.mismatch_cnt), 64'(sat(m_mm, 15)));
    check({tag, "_sready"}, 64'(bus.s_ready), 64'(0));
  endtask

  // Present one beat and wait, bounded, for it to be accepted.
  // The outputs are then checked just after the accepting edge.
  task automatic send_beat(input logic [7:0] s, input logic [7:0] r, input bit last);
    int waited = 0;
    bit done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      bus.s_valid       = 1'b1;
      bus.sender_bits   = s;
      bus.receiver_bits = r;
      bus.s_last        = last;
      if (bus.s_ready) begin
        @(posedge clk);
        #1;
        model_beat(s, r);
        done = 1'b1;
        if (last) begin
          bus.s_valid = 1'b0;
          check_result("frame");
        end else begin
          check_accum("beat");
        end
      end else begin
        waited++;
        if (waited >= 50) begin
          check("beat_accept_timeout", 64'(bus.s_ready), 64'(1));
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid       = 1'b0;
      bus.sender_bits   = 8'($urandom);
      bus.receiver_bits = 8'($urandom);
    end
  endtask

  // Hold off the consumer for a number of cycles and check the result is
  // stable meanwhile. Then take the result and check that everything clears.
  task automatic consume(input int stall);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_valid",  64'(bus.key_valid), 64'(1));
      check("hold_key",    64'(bus.key), 64'(m_key));
      check("hold_len",    64'(bus.key_len), 64'(m_len));
      check("hold_mm4",    64'(bus4.mismatch_cnt), 64'(sat(m_mm, 15)));
      check("hold_sready", 64'(bus.s_ready), 64'(0));
    end
    @(negedge clk);
    bus.key_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.key_ready = 1'b0;
    model_clear();
    check("take_valid",   64'(bus.key_valid), 64'(0));
    check("take_valid4",  64'(bus4.key_valid), 64'(0));
    check("take_key",     64'(bus.key), 64'(0));
    check("take_len",     64'(bus.key_len), 64'(0));
    check("take_short",   64'(bus.key_short), 64'(0));
    check("take_mm16",    64'(bus.mismatch_cnt), 64'(0));
    check("take_mm4",     64'(bus4.mismatch_cnt), 64'(0));
    check("take_sready",  64'(bus.s_ready), 64'(1));
    check("take_sready4", 64'(bus4.s_ready), 64'(1));
  endtask

  // Reset with a valid beat presented; the beat must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n             = 1'b0;
    bus.s_valid       = 1'b1;
    bus.sender_bits   = 8'hFF;
    bus.receiver_bits = 8'hFF;
    bus.s_last        = 1'b0;
    #1;
    check("rst_sready", 64'(bus.s_ready), 64'(0));
    @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.key_valid), 64'(0));
    check("rst_key",   64'(bus.key), 64'(0));
    check("rst_len",   64'(bus.key_len), 64'(0));
    check("rst_short", 64'(bus.key_short), 64'(0));
    check("rst_mm",    64'(bus.mismatch_cnt), 64'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    logic [7:0] r;
    int nb;
    bit aborted;

    bus.s_valid       = 1'b0;
    bus.s_last        = 1'b0;
    bus.sender_bits   = 8'h00;
    bus.receiver_bits = 8'h00;
    bus.key_ready     = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid",  64'(bus.key_valid), 64'(0));
    check("reset_key",    64'(bus.key), 64'(0));
    check("reset_len",    64'(bus.key_len), 64'(0));
    check("reset_mm",     64'(bus.mismatch_cnt), 64'(0));
    check("reset_sready", 64'(bus.s_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // full key
    send_beat(8'hA5, 8'hA5, 1'b0);
    send_beat(8'h3C, 8'h3C, 1'b1);
    check("t1_key", 64'(bus.key), 64'(16'h3CA5));
    check("t1_len", 64'(bus.key_len), 64'(16));
    consume(0);

    // short key
    send_beat(8'hFF, 8'h0F, 1'b1);
    check("t2_key",   64'(bus.key), 64'(16'h000F));
    check("t2_short", 64'(bus.key_short), 64'(1));
    check("t2_mm",    64'(bus.mismatch_cnt), 64'(4));
    consume(2);

    // overflow: the third beat's bits are dropped
    send_beat(8'h11, 8'h11, 1'b0);
    send_beat(8'h22, 8'h22, 1'b0);
    send_beat(8'h33, 8'h33, 1'b1);
    check("t3_key",   64'(bus.key), 64'(16'h2211));
    check("t3_short", 64'(bus.key_short), 64'(0));
    consume(1);

    // backpressure with a pending beat that must wait for the handshake
    send_beat(8'hA5, 8'hA5, 1'b0);
    send_beat(8'h3C, 8'h3C, 1'b1);
    bus.s_valid       = 1'b1;
    bus.sender_bits   = 8'h5A;
    bus.receiver_bits = 8'h5A;
    bus.s_last        = 1'b1;
    consume(5);
    send_beat(8'h5A, 8'h5A, 1'b1);
    check("t4_key", 64'(bus.key), 64'(16'h005A));
    check("t4_len", 64'(bus.key_len), 64'(8));
    consume(0);

    // reset mid-frame, then an independent frame
    send_beat(8'hFF, 8'hFF, 1'b0);
    do_reset();
    send_beat(8'hFF, 8'h0F, 1'b1);
    check("t5_key", 64'(bus.key), 64'(16'h000F));
    check("t5_len", 64'(bus.key_len), 64'(4));
    consume(0);

    // saturation of the narrow counter
    send_beat(8'h00, 8'hFF, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b1);
    check("t6_mm4",  64'(bus4.mismatch_cnt), 64'(15));
    check("t6_mm16", 64'(bus.mismatch_cnt), 64'(24));
    check("t6_len",  64'(bus4.key_len), 64'(0));
    consume(0);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      nb = $urandom_range(1, 5);
      aborted = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if (!aborted) begin
          idle($urandom_range(0, 2));
          s = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            r = 8'($urandom);
          end else begin
            r = s ^ 8'($urandom & $urandom & $urandom);
          end
          if (b == 1 && $urandom_range(0, 9) == 0) begin
            do_reset();
            aborted = 1'b1;
          end else begin
            send_beat(s, r, b == nb - 1);
          end
        end
      end
      if (!aborted) begin
        consume($urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
